h14tx_tmds_multi_encoder: RTL and testbench
===========================================

// Module: h14tx_tmds_multi_encoder
// PURPOSE
//   Multi-channel HDMI 1.4 TMDS symbol encoder. Per channel, one 10-bit symbol per valid cycle in one of five modes:
//   video (8b10b with DC balance), control, TERC4 data island, video guard band, data-island guard band.
//   Sits between the video/packet scheduler and the 10:1 serialisers.
//   Adds channel count, mode muxing, in-band valid and a pipelined output.
// PARAMETERS
//   CHANNELS  3  number of TMDS data channels; lane c uses bit slices [c*W +: W]
//   PIPE      1  register stages after symbol generation, 1..3; total latency = PIPE+1 cycles
// PORTS
//   clk        in   1           symbol clock; sole clock domain
//   rst        in   1           synchronous reset, active-high
//   in_valid   in   1           inputs below are a new symbol slot this cycle
//   mode       in   3           0 CTRL, 1 VIDEO, 2 TERC4, 3 VGB, 4 DGB; 5..7 treated as CTRL
//   video      in   8*CHANNELS  pixel byte per channel (VIDEO)
//   ctrl       in   2*CHANNELS  {c1,c0} per channel (CTRL)
//   terc       in   4*CHANNELS  nibble per channel (TERC4; DGB channel 0)
//   symbol     out  10*CHANNELS encoded symbol per channel, bit 0 transmitted first
//   out_valid  out  1           symbol carries the slot launched PIPE+1 cycles earlier
// BEHAVIOUR
//   Pipeline
//     - Stage 0 registers inputs and mode.
//     - Symbol and disparity update are computed from stage 0.
//     - Symbol then passes PIPE registers.
//     - in_valid=1 at cycle t gives out_valid=1 at t+PIPE+1.
//     - No backpressure.
//     - Slots with in_valid=0 do not change disparity.
//     - For those slots, out_valid=0 and symbol holds its last value.
//   Reset
//     - All stages clear. out_valid=0.
//     - Every symbol lane = 10'b1101010100 (CTRL 00). All disparity counters = 0.
//     - Reset mid-stream discards in-flight slots.
//     - First post-reset valid slot starts from disparity 0.
//   VIDEO (per channel, independent signed 5-bit disparity cnt)
//     - n1 = popcount(d). XNOR chain if n1>4 or (n1==4 and d[0]==0), q_m[8]=0; else XOR chain, q_m[8]=1.
//     - N1/N0 = ones/zeros of q_m[7:0].
//     - If cnt==0 or N1==N0:
//       - sym = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}.
//       - cnt += q_m8 ? N1-N0 : N0-N1.
//     - Elif (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
//       - sym = {1, q_m8, ~q_m[7:0]}.
//       - cnt += N0-N1 + 2*q_m8.
//     - Else:
//       - sym = {0, q_m8, q_m[7:0]}.
//       - cnt += N1-N0 - 2*~q_m8.
//     - cnt stays within [-10,+10] and never wraps.
//   Disparity reset by mode
//     - Any valid slot in a non-VIDEO mode forces cnt=0 on all channels.
//     - Next video period restarts balanced.
//   CTRL: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011 (sym[9:0]).
//   TERC4 (sym[9:0]), nibbles 0..F:
//     1010011100 1001100011 1011100100 1011100010 0101110001 0100011110 0110001110 0100111100
//     1011001100 0100111001 0110011100 1011000111 1010001110 1001110001 0101100011 1011000011
//   VGB: ch0, ch2 = 1011001100; ch1 = 0100110011; channels ≥3 repeat the pattern mod 3.
//   DGB: ch0 = TERC4(terc[3:0]); other channels = 0100110011.
//   Mode switch takes effect on the very slot carrying the new mode (no extra latency).
// TESTING
//   - Reset, PIPE=1, hold in_valid=0 → out_valid=0, all lanes 1101010100; in_valid at t → out_valid at t+2.
//   - VIDEO 0x00 ×3 from cnt=0 → syms 0100000000, 1111111111, 0100000000; cnt -8, +2, -6.
//   - VIDEO 0xFF then CTRL slot then VIDEO 0x00 → cnt cleared by CTRL; 0x00 encodes 0100000000 (cnt 0 path).
//   - TERC4 sweep 0..F on each channel, plus DGB/VGB slots → exact table codes per channel index.
//   - Random 10k VIDEO bytes, in_valid toggled randomly, CHANNELS=4, PIPE=3 → decode matches input;
//     running disparity stays in [-10,+10].
//   - Assert rst mid-stream with slots in flight → next cycle out_valid=0, CTRL00 on all lanes; cnt restarts at 0.

Source files
------------

// File: rtl/h14tx_tmds_multi_encoder.sv
// Multi-lane HDMI 1.4 TMDS symbol encoder: video 8b10b with running disparity, control, TERC4
// and guard bands, behind a registered input stage and a PIPE-deep output pipeline.
module h14tx_tmds_multi_encoder #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned PIPE     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [2:0]               mode,
    input  logic [8*CHANNELS-1:0]    video,
    input  logic [2*CHANNELS-1:0]    ctrl,
    input  logic [4*CHANNELS-1:0]    terc,
    output logic [10*CHANNELS-1:0]   symbol,
    output logic                     out_valid
);

    typedef enum logic [2:0] {
        ModeCtrl  = 3'd0,
        ModeVideo = 3'd1,
        ModeTerc  = 3'd2,
        ModeVgb   = 3'd3,
        ModeDgb   = 3'd4
    } mode_e;

    localparam logic [9:0] SymCtrl00 = 10'b1101010100;
    localparam logic [9:0] SymGbA    = 10'b1011001100;
    localparam logic [9:0] SymGbB    = 10'b0100110011;
    localparam int unsigned SymW     = 10 * CHANNELS;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] n);
        logic [9:0] s;
        case (n)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000111;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Returns {next disparity, symbol}; disparity is kept in 6 bits so the update never wraps.
    function automatic logic [14:0] video_enc(input logic [7:0] d, input logic signed [4:0] cnt);
        logic [3:0]        n1_in;
        logic [3:0]        n1_qm;
        logic              use_xnor;
        logic [8:0]        qm;
        logic signed [5:0] diff;
        logic signed [5:0] acc;
        logic [9:0]        sym;
        n1_in = '0;
        for (int i = 0; i < 8; i++) begin
            n1_in = n1_in + {3'b000, d[i]};
        end
        use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !d[0]);
        qm    = '0;
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        n1_qm = '0;
        for (int i = 0; i < 8; i++) begin
            n1_qm = n1_qm + {3'b000, qm[i]};
        end
        // diff = N1 - N0 of q_m[7:0]
        diff = $signed({1'b0, n1_qm, 1'b0}) - 6'sd8;
        acc  = {cnt[4], cnt};
        if ((cnt == 5'sd0) || (diff == 6'sd0)) begin
            sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            acc = qm[8] ? (acc + diff) : (acc - diff);
        end else if ((!cnt[4] && (diff > 6'sd0)) || (cnt[4] && (diff < 6'sd0))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            acc = acc - diff + (qm[8] ? 6'sd2 : 6'sd0);
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            acc = acc + diff - (qm[8] ? 6'sd0 : 6'sd2);
        end
        return {acc[4:0], sym};
    endfunction

    // Stage 0: registered slot
    logic                    s0_valid_q, s0_valid_d;
    logic [2:0]              s0_mode_q, s0_mode_d;
    logic [8*CHANNELS-1:0]   s0_video_q, s0_video_d;
    logic [2*CHANNELS-1:0]   s0_ctrl_q, s0_ctrl_d;
    logic [4*CHANNELS-1:0]   s0_terc_q, s0_terc_d;

    logic signed [4:0]       cnt_q [CHANNELS];
    logic signed [4:0]       cnt_d [CHANNELS];

    logic [SymW-1:0]         sym_s0;
    logic [14:0]             venc;
    logic [9:0]              lane_sym;

    logic [SymW-1:0]         pipe_sym_q [PIPE];
    logic [SymW-1:0]         pipe_sym_d [PIPE];
    logic [PIPE-1:0]         pipe_vld_q, pipe_vld_d;

    always_comb begin
        s0_valid_d = in_valid;
        s0_mode_d  = mode;
        s0_video_d = video;
        s0_ctrl_d  = ctrl;
        s0_terc_d  = terc;
    end

    always_comb begin
        sym_s0   = '0;
        venc     = '0;
        lane_sym = SymCtrl00;
        for (int c = 0; c < CHANNELS; c++) begin
            venc     = video_enc(s0_video_q[c*8 +: 8], cnt_q[c]);
            cnt_d[c] = cnt_q[c];
            case (s0_mode_q)
                ModeVideo: lane_sym = venc[9:0];
                ModeTerc:  lane_sym = terc4_sym(s0_terc_q[c*4 +: 4]);
                ModeVgb:   lane_sym = ((c % 3) == 1) ? SymGbB : SymGbA;
                ModeDgb:   lane_sym = (c == 0) ? terc4_sym(s0_terc_q[3:0]) : SymGbB;
                default:   lane_sym = ctrl_sym(s0_ctrl_q[c*2 +: 2]);
            endcase
            // Any non-video slot rebalances every lane for the next video period
            if (s0_valid_q) begin
                cnt_d[c] = (s0_mode_q == ModeVideo) ? venc[14:10] : 5'sd0;
            end
            sym_s0[c*10 +: 10] = lane_sym;
        end
    end

    // Pipeline stages only load on valid so the output holds its last symbol through idle slots
    always_comb begin
        pipe_vld_d = '0;
        for (int k = 0; k < PIPE; k++) begin
            pipe_sym_d[k] = pipe_sym_q[k];
        end
        pipe_vld_d[0] = s0_valid_q;
        if (s0_valid_q) begin
            pipe_sym_d[0] = sym_s0;
        end
        for (int k = 1; k < PIPE; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            if (pipe_vld_q[k-1]) begin
                pipe_sym_d[k] = pipe_sym_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_mode_q  <= '0;
            s0_video_q <= '0;
            s0_ctrl_q  <= '0;
            s0_terc_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= 5'sd0;
            end
            pipe_vld_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                pipe_sym_q[k] <= {CHANNELS{SymCtrl00}};
            end
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_mode_q  <= s0_mode_d;
            s0_video_q <= s0_video_d;
            s0_ctrl_q  <= s0_ctrl_d;
            s0_terc_q  <= s0_terc_d;
            for (int c = 0; c < CHANNELS; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            pipe_vld_q <= pipe_vld_d;
            for (int k = 0; k < PIPE; k++) begin
                pipe_sym_q[k] <= pipe_sym_d[k];
            end
        end
    end

    assign symbol    = pipe_sym_q[PIPE-1];
    assign out_valid = pipe_vld_q[PIPE-1];

endmodule

// File: tb/tb_h14tx_tmds_multi_encoder.sv
// Scoreboard bench for h14tx_tmds_multi_encoder (4 lanes, PIPE=1) with hand-computed symbols.
module tb_h14tx_tmds_multi_encoder;

    localparam int unsigned CH   = 4;
    localparam int unsigned PIPE = 1;
    localparam int unsigned W    = 10 * CH;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] GA  = 10'b1011001100;
    localparam logic [9:0] GB  = 10'b0100110011;
    localparam logic [9:0] TERC [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [2:0]        mode = 3'd0;
    logic [8*CH-1:0]   video = '0;
    logic [2*CH-1:0]   ctrl = '0;
    logic [4*CH-1:0]   terc = '0;
    logic [W-1:0]      symbol;
    logic              out_valid;

    h14tx_tmds_multi_encoder #(
        .CHANNELS (CH),
        .PIPE     (PIPE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mode      (mode),
        .video     (video),
        .ctrl      (ctrl),
        .terc      (terc),
        .symbol    (symbol),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sym;
        int           cyc;
        int           tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    logic rst_seen = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   tag_ctr = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    function automatic logic [W-1:0] lanes(input logic [9:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic slot(input logic [2:0] m, input logic [8*CH-1:0] v, input logic [2*CH-1:0] c,
                        input logic [4*CH-1:0] t, input logic [W-1:0] exp_sym);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        mode     = m;
        video    = v;
        ctrl     = c;
        terc     = t;
        e.sym    = exp_sym;
        e.cyc    = cyc + PIPE + 1;
        e.tag    = tag_ctr;
        tag_ctr++;
        sb.push_back(e);
    endtask

    // Idle slots carry junk data that must be ignored
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            mode     = 3'($urandom);
            video    = 32'($urandom);
            ctrl     = 8'($urandom);
            terc     = 16'($urandom);
        end
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
    endtask

    // Monitor
    initial begin
        logic [W-1:0] last_sym;
        exp_t e;
        last_sym = {CH{C00}};
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                check_int("reset_out_valid", int'(out_valid), 0);
                check("reset_symbol", symbol, {CH{C00}});
                last_sym = {CH{C00}};
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    check_int("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("slot%0d_symbol", e.tag), symbol, e.sym);
                    check_int($sformatf("slot%0d_latency_cycle", e.tag), cyc, e.cyc);
                    last_sym = e.sym;
                end
            end else begin
                check("idle_hold", symbol, last_sym);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]    e;
        logic [4*CH-1:0] t;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // 0x00 x3 from balanced: cnt -8, +2, -6
        slot(3'd1, {4{8'h00}}, '0, '0, {4{10'b0100000000}});
        slot(3'd1, {4{8'h00}}, '0, '0, {4{10'b1111111111}});
        slot(3'd1, {4{8'h00}}, '0, '0, {4{10'b0100000000}});
        // CTRL clears disparity
        slot(3'd0, '0, {2'b11, 2'b10, 2'b01, 2'b00}, '0, lanes(C00, C01, C10, C11));
        slot(3'd1, {4{8'hFF}}, '0, '0, {4{10'b1000000000}});
        // mode 7 behaves as CTRL and clears cnt=-8
        slot(3'd7, '0, {2'b00, 2'b01, 2'b10, 2'b11}, '0, lanes(C11, C10, C01, C00));
        slot(3'd1, {4{8'h00}}, '0, '0, {4{10'b0100000000}});
        // invalid gap must not touch cnt=-8
        idle(2);
        slot(3'd1, {4{8'h00}}, '0, '0, {4{10'b1111111111}});
        slot(3'd2, '0, '0, {4'h3, 4'h2, 4'h1, 4'h0}, lanes(TERC[0], TERC[1], TERC[2], TERC[3]));
        slot(3'd1, {4{8'h00}}, '0, '0, {4{10'b0100000000}});

        for (int n = 0; n < 16; n++) begin
            t = '0;
            e = '0;
            for (int c = 0; c < int'(CH); c++) begin
                t[c*4 +: 4]   = 4'(n + c);
                e[c*10 +: 10] = TERC[(n + c) % 16];
            end
            slot(3'd2, '0, '0, t, e);
        end

        slot(3'd3, '0, '0, '0, lanes(GA, GB, GA, GA));
        slot(3'd4, '0, '0, {4'h5, 4'h5, 4'h5, 4'hA}, lanes(TERC[10], GB, GB, GB));
        slot(3'd4, '0, '0, {4'hF, 4'hF, 4'hF, 4'h3}, lanes(TERC[3], GB, GB, GB));

        // Per-lane bytes 00/FF/10/55 exercising every disparity branch
        slot(3'd1, {8'h55, 8'h10, 8'hFF, 8'h00}, '0, '0,
             lanes(10'b0100000000, 10'b1000000000, 10'b0111110000, 10'b0100110011));
        slot(3'd1, {8'h55, 8'h10, 8'hFF, 8'h00}, '0, '0,
             lanes(10'b1111111111, 10'b0011111111, 10'b0111110000, 10'b0100110011));
        idle(1);
        slot(3'd1, {8'h55, 8'h10, 8'hFF, 8'h00}, '0, '0,
             lanes(10'b0100000000, 10'b0011111111, 10'b0111110000, 10'b0100110011));
        slot(3'd1, {8'h55, 8'h10, 8'hFF, 8'h00}, '0, '0,
             lanes(10'b1111111111, 10'b1000000000, 10'b0111110000, 10'b0100110011));
        // In-flight slot discarded by reset
        slot(3'd1, {4{8'hFF}}, '0, '0, {4{10'b1000000000}});
        reset_pulse();
        idle(2);
        slot(3'd1, {4{8'h00}}, '0, '0, {4{10'b0100000000}});
        slot(3'd1, {4{8'h00}}, '0, '0, {4{10'b1111111111}});
        idle(5);

        check_int("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
